// File: rtl/axil_reg_seq.sv
// AXI4-Lite register sequencer: writes NUM_REGS words from cfg_data, reads each back,
// and reports how many registers had a bad response or mismatched read data.
module axil_reg_seq #(
    parameter int NUM_REGS    = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     start,
    input  logic [31:0]              base_addr,
    input  logic [32*NUM_REGS-1:0]   cfg_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [3:0]               err_count,
    output logic [31:0]              M_AXI_AWADDR,
    output logic [2:0]               M_AXI_AWPROT,
    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [31:0]              M_AXI_WDATA,
    output logic [3:0]               M_AXI_WSTRB,
    output logic                     M_AXI_WVALID,
    input  logic                     M_AXI_WREADY,
    input  logic [1:0]               M_AXI_BRESP,
    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    output logic [31:0]              M_AXI_ARADDR,
    output logic [2:0]               M_AXI_ARPROT,
    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    input  logic [31:0]              M_AXI_RDATA,
    input  logic [1:0]               M_AXI_RRESP,
    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, NEXT} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [31:0]   base_q;
    logic [31:0]   awaddr, araddr, wdata;
    logic          awvalid, wvalid, aw_done, w_done;
    logic          bready, arvalid, rready;
    logic          err_flag;
    logic [3:0]    err_count_q;
    logic          busy_q, done_q, pass_q;

    logic [31:0]   word [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        assign word[g] = cfg_data[32*g +: 32];
    end

    function automatic logic [31:0] reg_addr(input logic [31:0] b, input logic [IW-1:0] i);
        return b + 32'(i) * 32'(ADDR_STRIDE);
    endfunction

    logic          aw_hs, w_hs;
    logic [IW-1:0] idx_inc;
    logic [3:0]    err_next;

    assign aw_hs    = awvalid && M_AXI_AWREADY;
    assign w_hs     = wvalid && M_AXI_WREADY;
    assign idx_inc  = idx + IW'(1);
    assign err_next = err_count_q + {3'b000, err_flag};

    // base_addr is captured at start so the address sequence cannot shift mid-run.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            idx         <= '0;
            base_q      <= '0;
            awaddr      <= '0;
            araddr      <= '0;
            wdata       <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            err_flag    <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= WADDR;
                        idx         <= '0;
                        base_q      <= base_addr;
                        awaddr      <= base_addr;
                        wdata       <= word[0];
                        awvalid     <= 1'b1;
                        wvalid      <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        err_flag    <= 1'b0;
                        err_count_q <= '0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                WADDR: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state  <= WRESP;
                        bready <= 1'b1;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        araddr  <= awaddr;
                        state   <= RADDR;
                        if (M_AXI_BRESP != 2'b00) err_flag <= 1'b1;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        rready <= 1'b0;
                        state  <= NEXT;
                        done_q <= (idx == LAST);
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != wdata) err_flag <= 1'b1;
                    end
                end
                NEXT: begin
                    // One increment per register no matter how many checks tripped.
                    done_q      <= 1'b0;
                    err_flag    <= 1'b0;
                    err_count_q <= err_next;
                    if (idx != LAST) begin
                        idx     <= idx_inc;
                        awaddr  <= reg_addr(base_q, idx_inc);
                        wdata   <= word[idx_inc];
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WADDR;
                    end else begin
                        busy_q <= 1'b0;
                        pass_q <= (err_next == 4'd0);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign M_AXI_AWADDR  = awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WDATA   = wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = bready;
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axil_reg_seq.sv
// Directed bench for axil_reg_seq: a mirroring AXI-Lite slave with error/delay knobs,
// hand-computed expectations checked with immediate assertions.
module tb_axil_reg_seq;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, pass;
    logic [3:0]   err_count;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
    logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RVALID, M_AXI_RREADY;

    axil_reg_seq #(.NUM_REGS(4), .ADDR_STRIDE(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .base_addr(base_addr),
        .cfg_data(cfg_data), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave knobs (driven by the stimulus block only)
    int          w_delay = 0;
    int          bresp_err_idx = -1;
    int          rd_bad_idx = -1;
    logic [31:0] rd_bad_val = '0;

    // Slave state and logs (owned by the slave process, cleared on reset)
    logic        aw_got, w_got, ar_got, prev_wpend;
    logic [31:0] last_wdata, prev_wdata;
    int          wr_n, rd_n, wcnt, aw_hi, w_hi, unstable, early_b;
    logic [31:0] aw_log[$], w_log[$], ar_log[$];

    assign M_AXI_AWREADY = 1'b1;
    assign M_AXI_WREADY  = M_AXI_WVALID && (wcnt >= w_delay);
    assign M_AXI_BVALID  = aw_got && w_got;
    assign M_AXI_BRESP   = (wr_n == bresp_err_idx) ? 2'b10 : 2'b00;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_RVALID  = ar_got;
    assign M_AXI_RDATA   = (rd_n == rd_bad_idx) ? rd_bad_val : last_wdata;
    assign M_AXI_RRESP   = 2'b00;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; prev_wpend <= 1'b0;
            last_wdata <= '0; prev_wdata <= '0;
            wr_n <= 0; rd_n <= 0; wcnt <= 0; aw_hi <= 0; w_hi <= 0; unstable <= 0; early_b <= 0;
            aw_log.delete(); w_log.delete(); ar_log.delete();
        end else begin
            if (M_AXI_AWVALID) aw_hi <= aw_hi + 1;
            if (M_AXI_WVALID) w_hi <= w_hi + 1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got <= 1'b1;
                aw_log.push_back(M_AXI_AWADDR);
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got <= 1'b1;
                last_wdata <= M_AXI_WDATA;
                w_log.push_back(M_AXI_WDATA);
            end
            wcnt <= (M_AXI_WVALID && !M_AXI_WREADY) ? wcnt + 1 : 0;
            prev_wpend <= M_AXI_WVALID && !M_AXI_WREADY;
            prev_wdata <= M_AXI_WDATA;
            if (prev_wpend && (!M_AXI_WVALID || M_AXI_WDATA != prev_wdata)) unstable <= unstable + 1;
            if (M_AXI_BREADY && !(aw_got && w_got)) early_b <= early_b + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                aw_got <= 1'b0; w_got <= 1'b0; wr_n <= wr_n + 1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_got <= 1'b1;
                ar_log.push_back(M_AXI_ARADDR);
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                ar_got <= 1'b0; rd_n <= rd_n + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic reset_dut();
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK);
    endtask

    // Pulses start, returns the sample cycle (1 = first cycle after start) where done is seen,
    // then steps one more cycle into IDLE. A start pulse may be injected at cycle pulse_at.
    task automatic run_seq(input int pulse_at, output int cyc);
        @(negedge ACLK) start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge ACLK);
            #1 cyc++;
            start = (cyc == pulse_at);
        end
        @(posedge ACLK);
        #1 start = 1'b0;
    endtask

    int cyc;
    int done_seen;

    initial begin
        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        chk("rst_awaddr", M_AXI_AWADDR, 32'd0);
        chk("rst_wdata", M_AXI_WDATA, 32'd0);

        // Mirroring slave, zero wait
        cfg_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
        base_addr = 32'h0;
        reset_dut();
        run_seq(0, cyc);
        chk("s1_done_cycle", 32'(cyc), 32'd20);
        chk("s1_pass", 32'(pass), 32'd1);
        chk("s1_err", 32'(err_count), 32'd0);
        chk("s1_busy_after", 32'(busy), 32'd0);
        chk("s1_done_pulse", 32'(done), 32'd0);
        chk("s1_nwr", 32'(aw_log.size()), 32'd4);
        chk("s1_aw3", q_at(aw_log, 3), 32'hC);
        chk("s1_ar1", q_at(ar_log, 1), 32'h4);
        chk("s1_ar2", q_at(ar_log, 2), 32'h8);
        chk("s1_w0", q_at(w_log, 0), 32'h0101FFFF);
        chk("s1_w2", q_at(w_log, 2), 32'hdead0011);
        chk("s1_strb_prot", 32'({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 32'h3C0);

        // Read-data mismatch on register 2; start raised in the done cycle must be ignored
        rd_bad_idx = 2; rd_bad_val = 32'hdead0010;
        reset_dut();
        run_seq(20, cyc);
        chk("s2_done_cycle", 32'(cyc), 32'd20);
        chk("s2_pass", 32'(pass), 32'd0);
        chk("s2_err", 32'(err_count), 32'd1);
        chk("s2_no_restart", 32'(busy), 32'd0);
        @(posedge ACLK); #1;
        chk("s2_idle_hold", 32'(busy), 32'd0);

        // BRESP error and read mismatch on the same register count once
        bresp_err_idx = 1; rd_bad_idx = 1; rd_bad_val = 32'h0;
        reset_dut();
        run_seq(0, cyc);
        chk("s3_err_once", 32'(err_count), 32'd1);
        chk("s3_pass", 32'(pass), 32'd0);
        chk("s3_nwr", 32'(aw_log.size()), 32'd4);
        chk("s3_aw2", q_at(aw_log, 2), 32'h8);
        chk("s3_w2", q_at(w_log, 2), 32'hdead0011);
        bresp_err_idx = -1; rd_bad_idx = -1;

        // WREADY delayed 3 cycles
        w_delay = 3;
        reset_dut();
        run_seq(0, cyc);
        chk("s4_done_cycle", 32'(cyc), 32'd32);
        chk("s4_aw_hi", 32'(aw_hi), 32'd4);
        chk("s4_w_hi", 32'(w_hi), 32'd16);
        chk("s4_wdata_stable", 32'(unstable), 32'd0);
        chk("s4_early_bready", 32'(early_b), 32'd0);
        chk("s4_pass", 32'(pass), 32'd1);
        w_delay = 0;

        // Reset during RDATA of register 2
        reset_dut();
        @(negedge ACLK) start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
        repeat (13) @(posedge ACLK);
        #1;
        chk("s5_in_rdata", 32'(M_AXI_RREADY), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("s5_valids_low", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge ACLK); #1;
            if (done) done_seen++;
        end
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK); #1;
        if (done) done_seen++;
        chk("s5_no_done", 32'(done_seen), 32'd0);
        run_seq(0, cyc);
        chk("s5_rerun_cycle", 32'(cyc), 32'd20);
        chk("s5_rerun_pass", 32'(pass), 32'd1);
        chk("s5_rerun_ar3", q_at(ar_log, 3), 32'hC);

        // Address wrap, start pulsed while busy
        base_addr = 32'hFFFF_FFF8;
        reset_dut();
        run_seq(7, cyc);
        chk("s6_done_cycle", 32'(cyc), 32'd20);
        chk("s6_nwr", 32'(aw_log.size()), 32'd4);
        chk("s6_aw0", q_at(aw_log, 0), 32'hFFFFFFF8);
        chk("s6_aw1", q_at(aw_log, 1), 32'hFFFFFFFC);
        chk("s6_ar2", q_at(ar_log, 2), 32'h0);
        chk("s6_ar3", q_at(ar_log, 3), 32'h4);
        chk("s6_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
